// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one single-port memory between fetch and data ports, data-first with a fetch anti-starvation override.
// Define ARB_BACK_TO_BACK_EN to let RESP re-arbitrate straight into ISSUE.
module cpu_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
`ifdef ARB_BACK_TO_BACK_EN
    localparam logic B2B = 1'b1;
`else
    localparam logic B2B = 1'b0;
`endif
    localparam logic [3:0] LAT  = 4'(MEM_LAT);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state, state_n;
    logic [3:0] lat_cnt, starve_cnt;
    logic       own_if, own_we, arb, go, pick_if, capture;

    always_comb begin
        arb     = state == IDLE || (B2B && state == RESP);
        go      = arb && (if_req || dm_req);
        pick_if = if_req && (!dm_req || starve_cnt == SMAX);
        capture = state == WAIT && lat_cnt == 4'd1;
        state_n = go ? ISSUE : state == ISSUE ? WAIT : capture ? RESP : state == RESP ? IDLE : state;
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Strobes are registered off the arbitration decision so they line up with the ISSUE/RESP cycles.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            if_gnt     <= 1'b0;
            dm_gnt     <= 1'b0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            own_if     <= 1'b0;
            own_we     <= 1'b0;
        end else begin
            if_gnt   <= go && pick_if;
            dm_gnt   <= go && !pick_if;
            mem_en   <= go;
            mem_we   <= go && !pick_if && dm_we;
            if_valid <= capture && own_if;
            dm_valid <= capture && !own_if;
            lat_cnt  <= state == ISSUE ? LAT : state == WAIT ? lat_cnt - 4'd1 : lat_cnt;
            if (arb)
                starve_cnt <= (!if_req || pick_if) ? 4'd0 : starve_cnt == SMAX ? starve_cnt : starve_cnt + 4'd1;
            if (go) begin
                own_if   <= pick_if;
                own_we   <= !pick_if && dm_we;
                mem_addr <= pick_if ? if_addr : dm_addr;
                if (!pick_if) mem_wdata <= dm_wdata;
            end
            if (capture && own_if) if_rdata <= mem_rdata;
            if (capture && !own_if && !own_we) dm_rdata <= mem_rdata;
        end
    end

    assign busy = state != IDLE;
endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Shares one single-port synchronous memory between the CPU's instruction-fetch port and data-memory port so the single-cycle core can run against a unified memory. Sits between `cpu` and the memory inside the `sccomp_dataflow` top. It serialises accesses with a req/gnt/valid handshake, gives data accesses fixed priority, and includes an anti-starvation override for fetch.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from `mem_en` to valid `mem_rdata`; legal range 1..15
- STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win; legal range 1..15

Ports:
- clk_in  in  1  single clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-low; asserting it (0) clears all state immediately
- if_req  in  1  fetch request; held until `if_gnt`
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse; fetch accepted
- if_rdata  out  DATA_W  fetched word; stable from `if_valid` until the next fetch response
- if_valid  out  1  one-cycle pulse; `if_rdata` is valid
- dm_req  in  1  data request; held until `dm_gnt`
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_gnt  out  1  one-cycle pulse; data access accepted
- dm_rdata  out  DATA_W  read word; unchanged by writes
- dm_valid  out  1  one-cycle pulse; read data valid, or write complete
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable; qualified by `mem_en`
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** evaluate the requests sampled at the clock edge.
  - If any request is present, latch the winner (owner, we, addr, wdata) and go to ISSUE. Otherwise stay in IDLE.
- **Priority:** `dm` wins over `if`, except when `starve_cnt` == STARVE_MAX, in which case `if` wins.
- **ISSUE:** one cycle.
  - Drive `mem_en`=1 with the latched `mem_we`, `mem_addr` and `mem_wdata`.
  - Pulse the winner's `gnt` in this same cycle.
  - Go to WAIT with `lat_cnt` = MEM_LAT.
- **WAIT:** decrement `lat_cnt` each cycle.
  - In the cycle where `lat_cnt` == 1, capture `mem_rdata` into the owner's rdata register (reads only) and go to RESP.
- **RESP:** one cycle. Pulse the owner's `valid`, then go to IDLE.
- **starve_cnt** (4-bit, saturating at STARVE_MAX):
  - +1 on each arbitration where `if_req`=1 and `dm` wins.
  - Cleared on an `if` grant.
  - Cleared in any arbitration where `if_req`=0.
- Deasserting a request before its `gnt` is legal. The next arbitration re-samples the requests; nothing is queued.
- Request inputs are ignored in ISSUE, WAIT and RESP (only RESP in the back-to-back build; see Configuration).
- The `mem_*` outputs are registered. `mem_en` and `mem_we` are 0 outside ISSUE. `mem_addr` and `mem_wdata` hold their last values.

## Timing
- Reset values: all outputs 0, FSM in IDLE, `starve_cnt`=0, `lat_cnt`=0, rdata registers 0.
- Request sampled high at edge k:
  - ISSUE and `gnt` in cycle k+1
  - `mem_rdata` sampled at the end of cycle k+1+MEM_LAT
  - `valid` in cycle k+2+MEM_LAT
- Issue-to-issue period: MEM_LAT+3 cycles (MEM_LAT+2 with back-to-back).
- If `if_req` and `dm_req` are both high at the same edge, exactly one `gnt` fires. The loser keeps its request asserted.
- `gnt` and `valid` are never high for both ports in the same cycle.
- Reset asserted mid-transaction: the in-flight access is dropped with no `valid` pulse. `mem_en` drops immediately (asynchronously). Requesters must re-issue after reset is released.
- MEM_LAT=1: WAIT lasts exactly one cycle.

## Configuration
- `ARB_BACK_TO_BACK_EN`
  - **Defined:** RESP also performs arbitration. If a request is present, go directly to ISSUE instead of IDLE. Period is MEM_LAT+2 cycles, and `busy` stays high throughout.
  - **Undefined:** RESP always returns to IDLE. Period is MEM_LAT+3 cycles.

## Test plan
Use MEM_LAT=2 and STARVE_MAX=4 unless noted.
- **Reset:** hold `reset`=0 with both requests high. All outputs read 0, and no `gnt` fires until reset is released.
- **Single fetch:**
  - Stimulus: `if_req` at edge 0 with `if_addr`=0x00400004; memory returns 0x2408000A.
  - Required: `if_gnt` in cycle 1, `mem_en`=1 with `mem_addr`=0x00400004, then `if_valid` in cycle 4 with `if_rdata`=0x2408000A.
- **Conflict:**
  - Stimulus: both requests high; `dm_we`=1, `dm_addr`=0x10010000, `dm_wdata`=0xDEADBEEF.
  - Required: `dm_gnt` first, with `mem_we`=1. `dm_valid` fires and `dm_rdata` is unchanged. The `if` request is granted at the next arbitration.
- **Starvation:**
  - Stimulus: `dm_req` and `if_req` held high continuously.
  - Required: four `dm` grants, then the fifth grant goes to `if`, after which `starve_cnt` returns to 0.
- **Mid-op reset:** pull `reset` low during WAIT. No `valid` pulse appears, and `busy`=0 immediately.
- **Back-to-back:** with `ARB_BACK_TO_BACK_EN` defined and `if_req` held high, `mem_en` pulses every 4 cycles. Without the macro, it pulses every 5 cycles.
